// File: rtl/genesis_gamepads_multi_if.sv
// Pad-side bundle for genesis_gamepads_multi: raw pad lines, shared TH select, committed results.
// master = the pad controller, slave = whatever drives the pad pins and consumes the decoded words.
interface genesis_gamepads_multi_if #(
  parameter int PORTS = 2
);
  logic [6*PORTS-1:0]  iGENPAD;
  logic [PORTS-1:0]    oGENPAD_SELECT;
  logic [2*PORTS-1:0]  oGENPAD_TYPE;
  logic [12*PORTS-1:0] oGENPAD_DECODED;
  logic                oGENPAD_VALID;
`ifdef GENPAD_VSYNC_POLL_EN
  logic                iVSYNC;
`endif

  modport master (
    input  iGENPAD,
    output oGENPAD_SELECT,
    output oGENPAD_TYPE,
    output oGENPAD_DECODED,
    output oGENPAD_VALID
`ifdef GENPAD_VSYNC_POLL_EN
    , input iVSYNC
`endif
  );

  modport slave (
    output iGENPAD,
    input  oGENPAD_SELECT,
    input  oGENPAD_TYPE,
    input  oGENPAD_DECODED,
    input  oGENPAD_VALID
`ifdef GENPAD_VSYNC_POLL_EN
    , output iVSYNC
`endif
  );
endinterface

// File: rtl/genesis_gamepads_multi.sv
// PORTS-wide Genesis/MS pad poller: one 8-step TH sequence per poll, results committed with a 1-cycle VALID after step 7; no backpressure.
// Optional GENPAD_VSYNC_POLL_EN: IDLE exit additionally waits for a synchronised iVSYNC rising edge.
module genesis_gamepads_multi #(
  parameter int PORTS        = 2,
  parameter int SELECT_TICKS = 500,
  parameter int READ_LATENCY = 48,
  parameter int IDLE_TICKS   = 100000
) (
  input logic                      iCLK,
  input logic                      iRESET,
  genesis_gamepads_multi_if.master pad
);
  localparam int MAX_TICKS = (IDLE_TICKS > SELECT_TICKS) ? IDLE_TICKS : SELECT_TICKS;
  localparam int TW        = $clog2(MAX_TICKS + 1);
  localparam logic [TW-1:0] IDLE_END  = TW'(IDLE_TICKS);
  localparam logic [TW-1:0] STEP_END  = TW'(SELECT_TICKS - 1);
  localparam logic [TW-1:0] SAMPLE_AT = TW'(READ_LATENCY);

  typedef enum logic {ST_IDLE, ST_PHASE} state_t;

  state_t              state;
  logic [2:0]          step;
  logic [TW-1:0]       tick;
  logic [PORTS-1:0]    select_q;
  logic [PORTS-1:0]    present3;
  logic [PORTS-1:0]    cand6;
  logic [PORTS-1:0]    conf6;
  logic [11:0]         shadow [PORTS];
  logic [2*PORTS-1:0]  type_q;
  logic [12*PORTS-1:0] decoded_q;
  logic                valid_q;
  logic                idle_go;

  logic [5:0]          g      [PORTS];
  logic [1:0]          cw_type[PORTS];
  logic [11:0]         cw_dec [PORTS];

  // Shadow word layout {Z,Y,X,M,S,C,B,A,U,D,L,R}; commit masks what the detected type cannot report.
  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      g[p]       = pad.iGENPAD[6*p +: 6];
      cw_type[p] = conf6[p] ? 2'd2 : (present3[p] ? 2'd1 : 2'd0);
      cw_dec[p]  = shadow[p];
      if (cw_type[p] == 2'd0) begin
        cw_dec[p][7] = 1'b0;
        cw_dec[p][4] = 1'b0;
      end
      if (cw_type[p] != 2'd2) cw_dec[p][11:8] = 4'h0;
    end
  end

`ifdef GENPAD_VSYNC_POLL_EN
  logic [2:0] vs_sync;
  logic       vs_pend;
  logic       vs_rise;

  assign vs_rise = vs_sync[1] & ~vs_sync[2];
  assign idle_go = (state == ST_IDLE) && (tick == IDLE_END) && (vs_pend || vs_rise);

  // Early edges are remembered until IDLE_TICKS has elapsed; edges during PHASE are dropped.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      vs_sync <= 3'b000;
      vs_pend <= 1'b0;
    end else begin
      vs_sync <= {vs_sync[1:0], pad.iVSYNC};
      if (state != ST_IDLE || idle_go) vs_pend <= 1'b0;
      else if (vs_rise)                vs_pend <= 1'b1;
    end
  end
`else
  assign idle_go = (state == ST_IDLE) && (tick == IDLE_END);
`endif

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state     <= ST_IDLE;
      step      <= 3'd0;
      tick      <= '0;
      select_q  <= '1;
      present3  <= '0;
      cand6     <= '0;
      conf6     <= '0;
      for (int p = 0; p < PORTS; p++) shadow[p] <= 12'h000;
      type_q    <= '0;
      decoded_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (idle_go) begin
            state    <= ST_PHASE;
            step     <= 3'd0;
            tick     <= '0;
            select_q <= '0;
          end else if (tick != IDLE_END) begin
            tick <= tick + 1'b1;
          end
        end
        ST_PHASE: begin
          if (tick == SAMPLE_AT) begin
            for (int p = 0; p < PORTS; p++) begin
              case (step)
                3'd0: begin
                  shadow[p][7] <= ~g[p][5];
                  shadow[p][4] <= ~g[p][4];
                  present3[p]  <= (g[p][1:0] == 2'b00);
                  cand6[p]     <= 1'b0;
                  conf6[p]     <= 1'b0;
                end
                3'd1: begin
                  shadow[p][6]   <= ~g[p][5];
                  shadow[p][5]   <= ~g[p][4];
                  shadow[p][3:0] <= ~g[p][3:0];
                end
                3'd4: cand6[p] <= present3[p] & (g[p][3:0] == 4'b0000);
                3'd5: if (cand6[p]) shadow[p][11:8] <= ~g[p][3:0];
                3'd6: conf6[p] <= cand6[p] & (g[p][3:0] == 4'b1111);
                default: ;
              endcase
            end
          end
          if (tick == STEP_END) begin
            tick <= '0;
            if (step == 3'd7) begin
              state    <= ST_IDLE;
              select_q <= '1;
              valid_q  <= 1'b1;
              for (int p = 0; p < PORTS; p++) begin
                type_q[2*p +: 2]     <= cw_type[p];
                decoded_q[12*p +: 12] <= cw_dec[p];
              end
            end else begin
              step     <= step + 1'b1;
              select_q <= {PORTS{~step[0]}};
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign pad.oGENPAD_SELECT  = select_q;
  assign pad.oGENPAD_TYPE    = type_q;
  assign pad.oGENPAD_DECODED = decoded_q;
  assign pad.oGENPAD_VALID   = valid_q;
endmodule
